fetch_stage: RTL and testbench

Parametrised instruction-fetch stage for the pipelined RISC-V core. Owns the program counter and drives the instruction memory, which has a one-cycle registered read. Buffers returned instructions with their PCs in a small FIFO and hands them to decode over a valid/ready handshake. Adds what the fixed IF stage lacks: decode backpressure, a redirect that flushes wrong-path instructions, and configurable width and depth.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 72 +++++++
 rtl/fetch_stage.sv | 106 ++++++++++
 tb/tb_fetch_stage.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core front end: word widths, the NOP
// encoding and the {instr, pc} entry carried between fetch and decode.
package riscv_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    // addi x0, x0, 0
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched instructions until decode takes them.
// A flush empties it in one cycle; flush wins over a push or pop that cycle.
// DEPTH must be a power of two so the pointers wrap on their own.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  T                             i_push_data,
    input  logic                         i_pop,
    output T                             o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_empty;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // The upstream credit scheme never pushes into a full FIFO; the full
    // guard only keeps the pointers coherent if that were ever violated.
    assign w_push = i_push && !i_flush && !w_full;
    assign w_pop  = i_pop  && !i_flush && !w_empty;

    // Pointer and occupancy bookkeeping; reset and flush both empty the FIFO.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents need no reset because r_count gates validity.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues reads to a one-cycle
// registered instruction memory, buffers responses with their PCs and hands
// them to decode over valid/ready. A redirect flushes everything in flight.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter int              ADDR_W   = 8,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               i_clk,
    input  logic               i_reset,
    output logic               o_imem_req,
    output logic [ADDR_W-1:0]  o_imem_addr,
    input  logic [INSTR_W-1:0] i_imem_data,
    input  logic               i_redirect,
    input  logic [XLEN-1:0]    i_redirect_pc,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [INSTR_W-1:0] o_instr,
    output logic [XLEN-1:0]    o_pc
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int CRD_W = CNT_W + 1;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
    } entry_t;

    logic [XLEN-1:0]  r_fetch_pc;
    logic             r_inflight;
    logic [XLEN-1:0]  r_inflight_pc;

    logic [CNT_W-1:0] w_count;
    logic [CRD_W-1:0] w_credit;
    logic             w_valid;
    logic             w_pop;
    logic             w_push;
    logic             w_req;
    logic [XLEN-1:0]  w_redirect_pc;
    logic [1:0]       w_unused_pc_lsbs;
    entry_t           w_push_entry;
    entry_t           w_head;

    assign w_valid = (w_count != '0);
    assign w_pop   = w_valid && i_ready;

    // Slots that will be committed after this cycle: buffered entries minus the
    // one decode is taking now, plus the response still coming back. Counting
    // the pop lets a two-deep FIFO keep one fetch per cycle flowing.
    assign w_credit = CRD_W'(w_count) - CRD_W'(w_pop) + CRD_W'(r_inflight);

    assign w_req = !i_reset && !i_redirect && (w_credit < CRD_W'(DEPTH));

    // A response is only meaningful if nothing flushed it this cycle; the
    // FIFO's own flush input drops it on redirect.
    assign w_push = r_inflight;

    assign w_redirect_pc    = {i_redirect_pc[XLEN-1:2], 2'b00};
    assign w_unused_pc_lsbs = i_redirect_pc[1:0];

    assign w_push_entry.instr = i_imem_data;
    assign w_push_entry.pc    = r_inflight_pc;

    // Fetch PC and in-flight tracking: reset, then redirect, then normal issue.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (i_redirect) begin
            r_fetch_pc    <= w_redirect_pc;
            r_inflight    <= 1'b0;
        end else begin
            r_inflight <= w_req;
            if (w_req) begin
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + XLEN'(4);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_flush     (i_redirect),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign o_imem_req  = w_req;
    assign o_imem_addr = r_fetch_pc[ADDR_W+1:2];
    assign o_valid     = w_valid;
    assign o_instr     = w_valid ? w_head.instr : '0;
    assign o_pc        = w_valid ? w_head.pc    : '0;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed timing scenarios followed by random
// ready/redirect/reset traffic, with a scoreboard of the expected
// instruction stream checked by an independent monitor.
module tb_fetch_stage;

    localparam int              XLEN     = 32;
    localparam int              ADDR_W   = 8;
    localparam int              DEPTH    = 4;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              o_imem_req;
    logic [ADDR_W-1:0] o_imem_addr;
    logic [31:0]       i_imem_data;
    logic              i_redirect;
    logic [XLEN-1:0]   i_redirect_pc;
    logic              o_valid;
    logic              i_ready;
    logic [31:0]       o_instr;
    logic [XLEN-1:0]   o_pc;

    int checks    = 0;
    int errors    = 0;
    int popsSeen  = 0;
    int reqCount  = 0;

    typedef struct {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } exp_t;

    exp_t            expQ[$];
    logic [XLEN-1:0] nextPc;

    fetch_stage #(
        .XLEN     (XLEN),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_data   (i_imem_data),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_instr       (o_instr),
        .o_pc          (o_pc)
    );

    always #5 i_clk = ~i_clk;

    // Memory contents are a scrambled function of the word index so that a
    // wrong address or a stale word shows up as a different instruction.
    function automatic logic [31:0] memWord(input logic [ADDR_W-1:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
    endfunction

    function automatic logic [ADDR_W-1:0] wordOf(input logic [XLEN-1:0] pc);
        return pc[ADDR_W+1:2];
    endfunction

    // One-cycle registered read; without a request the bus carries garbage.
    always @(posedge i_clk) begin
        if (o_imem_req) i_imem_data <= memWord(o_imem_addr);
        else            i_imem_data <= $urandom;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic appendExpected();
        exp_t e;
        e.pc    = nextPc;
        e.instr = memWord(wordOf(nextPc));
        expQ.push_back(e);
        nextPc  = nextPc + 32'd4;
    endtask

    // After reset or redirect, decode must see a sequential stream from here.
    task automatic startStream(input logic [XLEN-1:0] pc);
        expQ.delete();
        nextPc = {pc[XLEN-1:2], 2'b00};
        repeat (16) appendExpected();
    endtask

    // Drive one cycle of inputs just after the rising edge.
    task automatic applyStimulus(input logic rst, input logic rdr,
                                 input logic [XLEN-1:0] rpc, input logic rdy);
        @(posedge i_clk);
        #1;
        i_reset       = rst;
        i_redirect    = rdr;
        i_redirect_pc = rpc;
        i_ready       = rdy;
        if (rst)      startStream(RESET_PC);
        else if (rdr) startStream(rpc);
    endtask

    // Monitor: every accepted head (outside reset/redirect cycles, where the
    // pop is squashed by decode) must match the front of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (i_reset === 1'b0 && i_redirect === 1'b0 &&
                o_valid === 1'b1 && i_ready === 1'b1) begin
                popsSeen++;
                if (expQ.size() == 0) begin
                    checkOutput("scoreboard empty on pop", 64'd1, 64'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("pop pc", o_pc, e.pc);
                    checkOutput("pop instr", o_instr, e.instr);
                    appendExpected();
                end
            end
        end
    end

    initial begin
        i_reset       = 1'b1;
        i_redirect    = 1'b0;
        i_redirect_pc = '0;
        i_ready       = 1'b1;
        startStream(RESET_PC);

        // Reset values
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        @(negedge i_clk);
        checkOutput("reset o_valid", o_valid, 0);
        checkOutput("reset o_imem_req", o_imem_req, 0);
        checkOutput("reset o_imem_addr", o_imem_addr, wordOf(RESET_PC));
        checkOutput("reset o_instr", o_instr, 0);
        checkOutput("reset o_pc", o_pc, 0);

        // Free run from reset: request in cycle 0, valid from cycle 2, no gaps
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        @(negedge i_clk);
        checkOutput("first req", o_imem_req, 1);
        checkOutput("first addr", o_imem_addr, wordOf(RESET_PC));
        checkOutput("cycle0 valid", o_valid, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        @(negedge i_clk);
        checkOutput("cycle1 valid", o_valid, 0);
        for (int c = 2; c < 12; c++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b1);
            @(negedge i_clk);
            checkOutput("free-run valid", o_valid, 1);
        end

        // Backpressure: exactly DEPTH requests, then stall with head at RESET_PC
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        reqCount = 0;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0);
            @(negedge i_clk);
            if (o_imem_req) reqCount++;
        end
        checkOutput("bp request count", reqCount, DEPTH);
        checkOutput("bp req idle", o_imem_req, 0);
        checkOutput("bp head valid", o_valid, 1);
        checkOutput("bp head pc", o_pc, RESET_PC);
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b1);
            @(negedge i_clk);
            checkOutput("bp drain valid", o_valid, 1);
        end

        // Redirect with three entries buffered and one in flight
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h40, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        @(negedge i_clk);
        checkOutput("redir R+1 valid", o_valid, 0);
        checkOutput("redir R+1 addr", o_imem_addr, 8'h10);
        checkOutput("redir R+1 req", o_imem_req, 1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        @(negedge i_clk);
        checkOutput("redir R+2 valid", o_valid, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        @(negedge i_clk);
        checkOutput("redir R+3 valid", o_valid, 1);
        checkOutput("redir R+3 pc", o_pc, 32'h40);
        for (int c = 0; c < 6; c++) applyStimulus(1'b0, 1'b0, '0, 1'b1);

        // Misaligned redirect while decode pops the head
        @(negedge i_clk);
        checkOutput("pop before redirect", o_valid, 1);
        applyStimulus(1'b0, 1'b1, 32'h23, 1'b1);
        @(negedge i_clk);
        checkOutput("pop in redirect cycle", o_valid && i_ready, 1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        @(negedge i_clk);
        checkOutput("misaligned addr", o_imem_addr, 8'h08);
        for (int c = 0; c < 8; c++) applyStimulus(1'b0, 1'b0, '0, 1'b1);

        // Reset mid-operation with buffered entries and a request in flight
        for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        @(negedge i_clk);
        checkOutput("post-reset c0 valid", o_valid, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        @(negedge i_clk);
        checkOutput("post-reset c1 valid", o_valid, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        @(negedge i_clk);
        checkOutput("post-reset first pc", o_pc, RESET_PC);

        // Wrap-around of PC and word index
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        @(negedge i_clk);
        checkOutput("wrap addr R+1", o_imem_addr, 8'hFF);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        @(negedge i_clk);
        checkOutput("wrap addr R+2", o_imem_addr, 8'h00);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        @(negedge i_clk);
        checkOutput("wrap pc R+3", o_pc, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        @(negedge i_clk);
        checkOutput("wrap pc R+4", o_pc, 32'h0000_0000);

        // Random traffic: ready jitter, occasional redirects and resets
        for (int c = 0; c < 3000; c++) begin
            int       r;
            logic [XLEN-1:0] rpc;
            r   = $urandom_range(0, 199);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom);
            applyStimulus(r < 2, (r >= 2) && (r < 8), rpc, $urandom_range(0, 9) < 7);
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        @(negedge i_clk);
        checkOutput("enough pops observed", popsSeen > 500, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
